// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI-mode command transmitter: frame geometry,
// FSM state type, common command indices and the frame-image helper.
package sd_pkg;

   localparam int SD_FRAME_BITS   = 48;
   localparam int SD_PAYLOAD_BITS = 40;
   localparam int SD_CRC_BITS     = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      GAP   = 2'd2
   } sd_tx_state_t;

   localparam logic [5:0] CMD0  = 6'd0;
   localparam logic [5:0] CMD8  = 6'd8;
   localparam logic [5:0] CMD17 = 6'd17;

   // Start bit, transmission bit, index, argument, zeroed CRC field (filled in
   // serially during transmission), end bit.
   function automatic logic [47:0] sd_frame_init(input logic [5:0]  idx,
                                                 input logic [31:0] arg);
      return {2'b01, idx, arg, 7'b0000000, 1'b1};
   endfunction

endpackage

// File: rtl/crc_7.sv
// Serial CRC-7 (x^7 + x^3 + 1) as used by SD commands; shifts one bit per
// valid_i and clears on rst.
module crc_7 (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_i,
   input  logic       dat_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q;
   logic       fb;

   assign fb    = dat_i ^ crc_q[6];
   assign crc_o = crc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= '0;
      end else if (valid_i) begin
         crc_q <= {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      end
   end

endmodule

// File: rtl/sd_cmd_tx.sv
// SD SPI-mode command serializer: emits the 48-bit command frame MSB-first with
// an on-the-fly CRC-7, then GAP_BITS trailing ones before pulsing done_o.
module sd_cmd_tx
   import sd_pkg::*;
#(
   parameter int unsigned GAP_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_en_i,
   input  logic        abort_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [5:0]  cmd_idx_i,
   input  logic [31:0] cmd_arg_i,
   output logic        sdo_o,
   output logic        sdo_oe_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [5:0] LAST_BIT  = 6'(SD_FRAME_BITS - 1);
   localparam logic [5:0] CRC_FIRST = 6'(SD_PAYLOAD_BITS);
   localparam logic [7:0] GAP_LAST  = (GAP_BITS == 0) ? 8'd0 : 8'(GAP_BITS - 1);
   localparam bit         NO_GAP    = (GAP_BITS == 0);

   sd_tx_state_t state_q;
   logic [47:0]  shreg_q;
   logic [5:0]   bit_cnt_q;
   logic [7:0]   gap_cnt_q;
   logic         ready_q;
   logic         oe_q;
   logic         busy_q;

   logic         accept;
   logic         in_crc;
   logic         crc_rst;
   logic         crc_valid;
   logic [2:0]   crc_sel;
   logic [6:0]   crc;

   // Handshake: a command transfers on a clock where cmd_valid_i && cmd_ready_o
   // are both high; ready is high only in IDLE, so requests while busy are ignored.
   assign accept    = (state_q == IDLE) && cmd_valid_i;
   assign crc_rst   = rst | accept;
   assign crc_valid = (state_q == FRAME) && bit_en_i && !abort_i && (bit_cnt_q < CRC_FIRST);
   assign in_crc    = (bit_cnt_q >= CRC_FIRST) && (bit_cnt_q < LAST_BIT);
   assign crc_sel   = 3'(LAST_BIT - 6'd1 - bit_cnt_q);

   // CRC bits come straight from the generator; it is frozen while they are sent.
   assign sdo_o = (state_q == FRAME) ? (in_crc ? crc[crc_sel] : shreg_q[47]) : 1'b1;

   assign done_o = !rst && !abort_i && bit_en_i &&
                   (((state_q == FRAME) && (bit_cnt_q == LAST_BIT) && NO_GAP) ||
                    ((state_q == GAP) && (gap_cnt_q == GAP_LAST)));

   assign cmd_ready_o = ready_q;
   assign sdo_oe_o    = oe_q;
   assign busy_o      = busy_q;

   crc_7 u_crc (
      .clk     (clk),
      .rst     (crc_rst),
      .valid_i (crc_valid),
      .dat_i   (shreg_q[47]),
      .crc_o   (crc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         ready_q   <= 1'b1;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid_i) begin
                  shreg_q   <= sd_frame_init(cmd_idx_i, cmd_arg_i);
                  bit_cnt_q <= '0;
                  state_q   <= FRAME;
                  ready_q   <= 1'b0;
                  oe_q      <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            FRAME: begin
               if (abort_i) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  oe_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (bit_en_i) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     oe_q <= 1'b0;
                     if (NO_GAP) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q   <= GAP;
                        gap_cnt_q <= '0;
                     end
                  end else begin
                     shreg_q   <= {shreg_q[46:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            GAP: begin
               if (abort_i || (bit_en_i && (gap_cnt_q == GAP_LAST))) begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
                  oe_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (bit_en_i) begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               oe_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: two builds (GAP_BITS 8 and 0) share stimulus; expected
// bit streams come from a polynomial-division CRC-7 model of the SD frame.
module tb_sd_cmd_tx;
   import sd_pkg::*;

   logic        clk;
   logic        rst;
   logic        bit_en_i;
   logic        abort_i;
   logic        cmd_valid_i;
   logic [5:0]  cmd_idx_i;
   logic [31:0] cmd_arg_i;

   logic o8_ready, o8_sdo, o8_oe, o8_busy, o8_done;
   logic o0_ready, o0_sdo, o0_oe, o0_busy, o0_done;

   logic sel0;
   logic m_ready, m_sdo, m_oe, m_busy, m_done;

   int n_checks;
   int n_fail;

   // Each entry is {sdo_oe_o, sdo_o} seen on a bit strobe while busy.
   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];

   sd_cmd_tx #(.GAP_BITS(8)) u_dut8 (
      .clk         (clk),
      .rst         (rst),
      .bit_en_i    (bit_en_i),
      .abort_i     (abort_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (o8_ready),
      .cmd_idx_i   (cmd_idx_i),
      .cmd_arg_i   (cmd_arg_i),
      .sdo_o       (o8_sdo),
      .sdo_oe_o    (o8_oe),
      .busy_o      (o8_busy),
      .done_o      (o8_done)
   );

   sd_cmd_tx #(.GAP_BITS(0)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .bit_en_i    (bit_en_i),
      .abort_i     (abort_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (o0_ready),
      .cmd_idx_i   (cmd_idx_i),
      .cmd_arg_i   (cmd_arg_i),
      .sdo_o       (o0_sdo),
      .sdo_oe_o    (o0_oe),
      .busy_o      (o0_busy),
      .done_o      (o0_done)
   );

   assign m_ready = sel0 ? o0_ready : o8_ready;
   assign m_sdo   = sel0 ? o0_sdo   : o8_sdo;
   assign m_oe    = sel0 ? o0_oe    : o8_oe;
   assign m_busy  = sel0 ? o0_busy  : o8_busy;
   assign m_done  = sel0 ? o0_done  : o8_done;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      bit_en_i    = 1'b0;
      abort_i     = 1'b0;
      cmd_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [6:0] model_crc(input logic [39:0] payload);
      logic [46:0] m;
      m = {payload, 7'b0000000};
      for (int i = 46; i >= 7; i--) begin
         if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
      end
      return m[6:0];
   endfunction

   function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] p;
      p = {2'b01, idx, arg};
      return {p, model_crc(p), 1'b1};
   endfunction

   task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input int gap);
      logic [47:0] f;
      f = model_frame(idx, arg);
      for (int i = 47; i >= 0; i--) exp_q.push_back({1'b1, f[i]});
      for (int i = 0; i < gap; i++) exp_q.push_back(2'b01);
   endtask

   function automatic int first_mismatch();
      if (got_q.size() != exp_q.size())
         return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] got_byte(input int start);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++)
         b = {b[6:0], (start + i < got_q.size()) ? got_q[start + i][0] : 1'bx};
      return b;
   endfunction

   function automatic int got_oe_count();
      int n;
      n = 0;
      foreach (got_q[i]) if (got_q[i][1]) n++;
      return n;
   endfunction

   // ---------------- driver ----------------
   // period 0 = random strobes, else one strobe every 'period' clocks.
   task automatic run_stream(input logic [5:0] idx1, input logic [31:0] arg1,
                             input logic [5:0] idx2, input logic [31:0] arg2,
                             input bit hold, input int period, input int n_done,
                             input int budget, output int strobes_at_done,
                             output int done_cnt, output int stray_done);
      int  cyc;
      int  cnt;
      int  accepts;
      int  strobes;
      bit  pend;
      cyc = 0; cnt = 0; accepts = 0; strobes = 0; pend = 0;
      done_cnt = 0; stray_done = 0; strobes_at_done = 0;
      while (done_cnt < n_done && cyc < budget) begin
         @(negedge clk);
         if (cyc == 0) begin
            cmd_valid_i = 1'b1;
            cmd_idx_i   = idx1;
            cmd_arg_i   = arg1;
         end
         if (pend) begin
            pend = 0;
            if (hold && accepts == 1) begin
               cmd_idx_i = idx2;
               cmd_arg_i = arg2;
            end else begin
               cmd_valid_i = 1'b0;
            end
         end
         if (period == 0) begin
            bit_en_i = ($urandom_range(0, 2) == 0);
         end else begin
            bit_en_i = (cnt == period - 1);
            cnt      = (cnt == period - 1) ? 0 : cnt + 1;
         end
         #1;
         if (cmd_valid_i && m_ready) begin
            accepts++;
            pend = 1;
         end
         if (m_busy && bit_en_i) begin
            got_q.push_back({m_oe, m_sdo});
            strobes++;
         end
         if (m_done) begin
            done_cnt++;
            strobes_at_done = strobes;
            if (!bit_en_i) stray_done++;
         end
         cyc++;
      end
      @(negedge clk);
      bit_en_i    = 1'b0;
      cmd_valid_i = 1'b0;
   endtask

   // Accept one command and issue n random-spaced strobes; stops just before
   // the posedge that consumes the n-th strobe.
   task automatic advance(input logic [5:0] idx, input logic [31:0] arg, input int n,
                          output int strobes, output int dones);
      int cyc;
      cyc = 0; strobes = 0; dones = 0;
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_idx_i   = idx;
      cmd_arg_i   = arg;
      bit_en_i    = 1'b0;
      while (strobes < n && cyc < 1000) begin
         @(negedge clk);
         cmd_valid_i = 1'b0;
         bit_en_i    = ($urandom_range(0, 2) == 0);
         #1;
         if (m_busy && bit_en_i) strobes++;
         if (m_done) dones++;
         cyc++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; bit_en_i = 1'b0; abort_i = 1'b0; cmd_valid_i = 1'b0;
      cmd_idx_i = '0; cmd_arg_i = '0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if ({o8_ready, o8_sdo, o8_oe, o8_busy, o8_done} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_gap8: {ready,sdo,oe,busy,done} got %b expected 11000",
                  {o8_ready, o8_sdo, o8_oe, o8_busy, o8_done});
      end
      n_checks++;
      if ({o0_ready, o0_sdo, o0_oe, o0_busy, o0_done} !== 5'b11000) begin
         n_fail++;
         $display("FAIL reset_gap0: {ready,sdo,oe,busy,done} got %b expected 11000",
                  {o0_ready, o0_sdo, o0_oe, o0_busy, o0_done});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_stream(input string name, input int sad, input int exp_sad,
                               input int dc, input int exp_dc, input int stray);
      int mm;
      mm = first_mismatch();
      n_checks++;
      if (mm >= 0) begin
         n_fail++;
         $display("FAIL %s stream: first difference at bit %0d, got %0d entries expected %0d, got {oe,sdo}=%b expected %b",
                  name, mm, got_q.size(), exp_q.size(),
                  (mm < got_q.size()) ? got_q[mm] : 2'bxx,
                  (mm < exp_q.size()) ? exp_q[mm] : 2'bxx);
      end
      n_checks++;
      if (dc !== exp_dc) begin
         n_fail++;
         $display("FAIL %s done_count: got %0d expected %0d", name, dc, exp_dc);
      end
      n_checks++;
      if (sad !== exp_sad) begin
         n_fail++;
         $display("FAIL %s strobes_to_done: got %0d expected %0d", name, sad, exp_sad);
      end
      n_checks++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL %s done_without_strobe: got %0d expected 0", name, stray);
      end
   endtask

   task automatic test_cmd0();
      int sad, dc, stray;
      logic [7:0] b;
      do_reset();
      sel0 = 1'b0;
      got_q.delete(); exp_q.delete();
      push_frame(CMD0, 32'h0, 8);
      run_stream(CMD0, 32'h0, CMD0, 32'h0, 1'b0, 4, 1, 2000, sad, dc, stray);
      check_stream("cmd0", sad, 56, dc, 1, stray);
      n_checks++;
      if (got_oe_count() !== 48) begin
         n_fail++;
         $display("FAIL cmd0_oe_periods: got %0d expected 48", got_oe_count());
      end
      b = got_byte(40);
      n_checks++;
      if (b !== 8'h95) begin
         n_fail++;
         $display("FAIL cmd0_trailer: got %h expected 95", b);
      end
   endtask

   task automatic test_cmd8();
      int sad, dc, stray;
      logic [7:0] b;
      do_reset();
      sel0 = 1'b0;
      got_q.delete(); exp_q.delete();
      push_frame(CMD8, 32'h0000_01AA, 8);
      run_stream(CMD8, 32'h0000_01AA, CMD8, 32'h0, 1'b0, 0, 1, 2000, sad, dc, stray);
      check_stream("cmd8", sad, 56, dc, 1, stray);
      b = got_byte(40);
      n_checks++;
      if (b[7:1] !== 7'h43) begin
         n_fail++;
         $display("FAIL cmd8_crc: got %h expected 43", b[7:1]);
      end
      b = got_byte(0);
      n_checks++;
      if (b !== 8'h48) begin
         n_fail++;
         $display("FAIL cmd8_first_byte: got %h expected 48", b);
      end
   endtask

   task automatic test_random();
      int sad, dc, stray;
      logic [5:0]  idx;
      logic [31:0] arg;
      for (int k = 0; k < 4; k++) begin
         do_reset();
         sel0 = 1'b0;
         idx  = 6'($urandom_range(0, 63));
         arg  = $urandom;
         got_q.delete(); exp_q.delete();
         push_frame(idx, arg, 8);
         run_stream(idx, arg, idx, arg, 1'b0, (k == 0) ? 1 : 0, 1, 2000, sad, dc, stray);
         check_stream($sformatf("random%0d_idx%0d_arg%h", k, idx, arg), sad, 56, dc, 1, stray);
      end
   endtask

   task automatic test_back_to_back();
      int sad, dc, stray;
      logic [7:0] b;
      do_reset();
      sel0 = 1'b0;
      got_q.delete(); exp_q.delete();
      push_frame(CMD17, 32'h0, 8);
      push_frame(CMD0, 32'h0, 8);
      run_stream(CMD17, 32'h0, CMD0, 32'h0, 1'b1, 3, 2, 4000, sad, dc, stray);
      check_stream("back_to_back", sad, 112, dc, 2, stray);
      b = got_byte(40);
      n_checks++;
      if (b !== 8'h55) begin
         n_fail++;
         $display("FAIL b2b_cmd17_trailer: got %h expected 55", b);
      end
      b = got_byte(96);
      n_checks++;
      if (b !== 8'h95) begin
         n_fail++;
         $display("FAIL b2b_cmd0_trailer: got %h expected 95", b);
      end
   endtask

   task automatic test_abort();
      int strobes, dones, late_done, sad, dc, stray;
      do_reset();
      sel0 = 1'b0;
      advance(CMD8, 32'h0000_01AA, 20, strobes, dones);
      n_checks++;
      if (strobes !== 20) begin
         n_fail++;
         $display("FAIL abort_reach_bit20: got %0d strobes expected 20", strobes);
      end
      @(negedge clk);
      abort_i  = 1'b1;
      bit_en_i = 1'b1;
      #1;
      n_checks++;
      if (m_done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_cycle_done: got %b expected 0", m_done);
      end
      @(negedge clk);
      abort_i  = 1'b0;
      bit_en_i = 1'b0;
      #1;
      n_checks++;
      if ({m_ready, m_sdo, m_oe, m_busy, m_done} !== 5'b11000) begin
         n_fail++;
         $display("FAIL abort_outputs: {ready,sdo,oe,busy,done} got %b expected 11000",
                  {m_ready, m_sdo, m_oe, m_busy, m_done});
      end
      late_done = dones;
      repeat (30) begin
         @(negedge clk);
         bit_en_i = ($urandom_range(0, 1) == 0);
         #1;
         if (m_done || m_busy) late_done++;
      end
      n_checks++;
      if (late_done !== 0) begin
         n_fail++;
         $display("FAIL abort_stays_idle: got %0d done/busy cycles expected 0", late_done);
      end
      got_q.delete(); exp_q.delete();
      push_frame(CMD0, 32'h0, 8);
      run_stream(CMD0, 32'h0, CMD0, 32'h0, 1'b0, 0, 1, 2000, sad, dc, stray);
      check_stream("after_abort", sad, 56, dc, 1, stray);
   endtask

   task automatic test_rst_mid();
      int strobes, dones, sad, dc, stray;
      do_reset();
      sel0 = 1'b0;
      advance(CMD0, 32'h0, 43, strobes, dones);
      n_checks++;
      if (strobes !== 43) begin
         n_fail++;
         $display("FAIL rst_reach_bit43: got %0d strobes expected 43", strobes);
      end
      @(negedge clk);
      rst      = 1'b1;
      bit_en_i = 1'b1;
      #1;
      n_checks++;
      if (m_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_cycle_done: got %b expected 0", m_done);
      end
      @(negedge clk);
      rst      = 1'b0;
      bit_en_i = 1'b0;
      #1;
      n_checks++;
      if ({m_ready, m_sdo, m_oe, m_busy, m_done} !== 5'b11000) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: {ready,sdo,oe,busy,done} got %b expected 11000",
                  {m_ready, m_sdo, m_oe, m_busy, m_done});
      end
      got_q.delete(); exp_q.delete();
      push_frame(CMD17, 32'h0, 8);
      run_stream(CMD17, 32'h0, CMD17, 32'h0, 1'b0, 2, 1, 2000, sad, dc, stray);
      check_stream("after_rst", sad, 56, dc, 1, stray);
   endtask

   task automatic test_gap0();
      int sad, dc, stray;
      logic [7:0] b;
      do_reset();
      sel0 = 1'b1;
      got_q.delete(); exp_q.delete();
      push_frame(CMD0, 32'h0, 0);
      run_stream(CMD0, 32'h0, CMD0, 32'h0, 1'b0, 1, 1, 500, sad, dc, stray);
      check_stream("gap0_continuous", sad, 48, dc, 1, stray);
      b = got_byte(40);
      n_checks++;
      if (b !== 8'h95) begin
         n_fail++;
         $display("FAIL gap0_trailer: got %h expected 95", b);
      end
      got_q.delete(); exp_q.delete();
      push_frame(CMD8, 32'h0000_01AA, 0);
      run_stream(CMD8, 32'h0000_01AA, CMD8, 32'h0, 1'b0, 0, 1, 2000, sad, dc, stray);
      check_stream("gap0_random", sad, 48, dc, 1, stray);
      sel0 = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks    = 0;
      n_fail      = 0;
      sel0        = 1'b0;
      rst         = 1'b1;
      bit_en_i    = 1'b0;
      abort_i     = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_idx_i   = '0;
      cmd_arg_i   = '0;
      test_reset();
      test_cmd0();
      test_cmd8();
      test_random();
      test_back_to_back();
      test_abort();
      test_rst_mid();
      test_gap0();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
